// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha keystream engine.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  localparam word_t SIGMA0 = 32'h61707865;
  localparam word_t SIGMA1 = 32'h3320646e;
  localparam word_t SIGMA2 = 32'h79622d32;
  localparam word_t SIGMA3 = 32'h6b206574;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_ADD,
    S_OUT
  } fsm_t;

  function automatic bit rounds_ok(int r);
    return (r == 8) || (r == 12) || (r == 20);
  endfunction

  function automatic word_t rotl(word_t v, int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qround.sv
// Combinational ChaCha quarter-round (rotations 16/12/8/7).
module chacha_qround
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_o,
  output word_t b_o,
  output word_t c_o,
  output word_t d_o
);

  word_t a1, b1, c1, d1;

  always_comb begin
    a1  = a + b;
    d1  = rotl(d ^ a1, 16);
    c1  = c + d1;
    b1  = rotl(b ^ c1, 12);
    a_o = a1 + b1;
    d_o = rotl(d1 ^ a_o, 8);
    c_o = c1 + d_o;
    b_o = rotl(b1 ^ c_o, 7);
  end

endmodule

// File: rtl/chacha_block_engine.sv
// ChaCha keystream engine: one half double-round per cycle, one 512-bit block per job step.
// Optional CHACHA_ZEROIZE_EN clears key and working state on the final block handshake.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int CTR_W  = 32,
  parameter int NBLK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [255:0]      key,
  input  logic [95:0]       nonce,
  input  logic [CTR_W-1:0]  init_ctr,
  input  logic [NBLK_W-1:0] num_blocks,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [511:0]      ks_block,
  output logic [CTR_W-1:0]  ks_ctr,
  output logic              ks_last,
  output logic              ctr_wrap,
  output logic              busy
);

  localparam int RND_W = $clog2(ROUNDS);

  if (!rounds_ok(ROUNDS)) begin : g_bad_rounds
    $error("chacha_block_engine: ROUNDS must be 8, 12 or 20");
  end
  if (CTR_W != 32 && CTR_W != 64) begin : g_bad_ctr
    $error("chacha_block_engine: CTR_W must be 32 or 64");
  end

  typedef struct packed {
    logic [255:0]      key;
    logic [95:0]       nonce;
    logic [CTR_W-1:0]  ctr;
    logic [NBLK_W-1:0] rem;
  } job_t;

  fsm_t             st;
  job_t             job_q;
  state_t           x, s, init_st, x_nxt, sum;
  logic [RND_W-1:0] rnd;
  logic [63:0]      c64;
  logic             ctr_max;
  logic             diag;

  word_t [3:0] qa, qb, qc, qd;
  word_t [3:0] ra, rb, rc, rd;

  assign c64     = 64'(job_q.ctr);
  assign ctr_max = &job_q.ctr;
  assign diag    = rnd[0];

  always_comb begin
    init_st     = '0;
    init_st[0]  = SIGMA0;
    init_st[1]  = SIGMA1;
    init_st[2]  = SIGMA2;
    init_st[3]  = SIGMA3;
    for (int i = 0; i < 8; i++) init_st[4+i] = job_q.key[32*i +: 32];
    init_st[12] = c64[31:0];
    init_st[13] = (CTR_W == 64) ? c64[63:32] : job_q.nonce[31:0];
    init_st[14] = job_q.nonce[63:32];
    init_st[15] = job_q.nonce[95:64];
  end

  // Lane g always owns word g as 'a'; b/c/d rotate by 1/2/3 on diagonal rounds.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int BC = 4 + g;
    localparam int BD = 4 + ((g + 1) % 4);
    localparam int CC = 8 + g;
    localparam int CD = 8 + ((g + 2) % 4);
    localparam int DC = 12 + g;
    localparam int DD = 12 + ((g + 3) % 4);

    assign qa[g] = x[g];
    assign qb[g] = diag ? x[BD] : x[BC];
    assign qc[g] = diag ? x[CD] : x[CC];
    assign qd[g] = diag ? x[DD] : x[DC];

    chacha_qround u_qr (
      .a   (qa[g]),
      .b   (qb[g]),
      .c   (qc[g]),
      .d   (qd[g]),
      .a_o (ra[g]),
      .b_o (rb[g]),
      .c_o (rc[g]),
      .d_o (rd[g])
    );
  end

  always_comb begin
    x_nxt = x;
    for (int g = 0; g < 4; g++) begin
      x_nxt[g] = ra[g];
      if (diag) begin
        x_nxt[4  + ((g + 1) % 4)] = rb[g];
        x_nxt[8  + ((g + 2) % 4)] = rc[g];
        x_nxt[12 + ((g + 3) % 4)] = rd[g];
      end else begin
        x_nxt[4  + g] = rb[g];
        x_nxt[8  + g] = rc[g];
        x_nxt[12 + g] = rd[g];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) sum[i] = x[i] + s[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      job_ready <= 1'b1;
      busy      <= 1'b0;
      ks_valid  <= 1'b0;
      ks_block  <= '0;
      ks_ctr    <= '0;
      ks_last   <= 1'b0;
      ctr_wrap  <= 1'b0;
      job_q     <= '0;
      x         <= '0;
      s         <= '0;
      rnd       <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (job_valid) begin
            job_q.key   <= key;
            job_q.nonce <= nonce;
            job_q.ctr   <= init_ctr;
            job_q.rem   <= (num_blocks == '0) ? NBLK_W'(1) : num_blocks;
            ctr_wrap    <= 1'b0;
            job_ready   <= 1'b0;
            busy        <= 1'b1;
            st          <= S_LOAD;
          end
        end
        S_LOAD: begin
          x   <= init_st;
          s   <= init_st;
          rnd <= '0;
          st  <= S_ROUND;
        end
        S_ROUND: begin
          x   <= x_nxt;
          rnd <= rnd + RND_W'(1);
          if (rnd == RND_W'(ROUNDS - 1)) st <= S_ADD;
        end
        S_ADD: begin
          ks_block <= sum;
          ks_ctr   <= job_q.ctr;
          ks_last  <= (job_q.rem == NBLK_W'(1)) || ctr_max;
          // Counter cannot advance past all-ones: truncate the job and flag it.
          if (ctr_max && job_q.rem > NBLK_W'(1)) ctr_wrap <= 1'b1;
          ks_valid <= 1'b1;
          st       <= S_OUT;
        end
        S_OUT: begin
          if (ks_ready) begin
            ks_valid <= 1'b0;
            if (ks_last) begin
              job_ready <= 1'b1;
              busy      <= 1'b0;
              st        <= S_IDLE;
`ifdef CHACHA_ZEROIZE_EN
              ks_block  <= '0;
              x         <= '0;
              s         <= '0;
              job_q.key <= '0;
`endif
            end else begin
              job_q.ctr <= job_q.ctr + CTR_W'(1);
              job_q.rem <= job_q.rem - NBLK_W'(1);
              st        <= S_LOAD;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_engine.sv
// Self-checking bench: software ChaCha model plus scoreboard for the default build,
// and two ROUNDS=8/12, CTR_W=64 instances checked directly.
module tb_chacha_block_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0, job_ready;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  init_ctr = '0;
  logic [15:0]  num_blocks = '0;
  logic         ks_valid, ks_ready = 1'b0;
  logic [511:0] ks_block;
  logic [31:0]  ks_ctr;
  logic         ks_last, ctr_wrap, busy;

  always #5 clk = ~clk;

  chacha_block_engine #(.ROUNDS(20), .CTR_W(32), .NBLK_W(16)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .key(key), .nonce(nonce), .init_ctr(init_ctr), .num_blocks(num_blocks),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_block(ks_block),
    .ks_ctr(ks_ctr), .ks_last(ks_last), .ctr_wrap(ctr_wrap), .busy(busy)
  );

  logic         a_jv[2], a_jr[2], a_kv[2], a_kr[2], a_last[2], a_wrap[2], a_busy[2];
  logic [255:0] a_key[2];
  logic [95:0]  a_non[2];
  logic [63:0]  a_ctr[2], a_ko[2];
  logic [15:0]  a_nb[2];
  logic [511:0] a_blk[2];

  for (genvar g = 0; g < 2; g++) begin : g_aux
    chacha_block_engine #(.ROUNDS(g == 0 ? 8 : 12), .CTR_W(64), .NBLK_W(16)) u_aux (
      .clk(clk), .rst(rst), .job_valid(a_jv[g]), .job_ready(a_jr[g]),
      .key(a_key[g]), .nonce(a_non[g]), .init_ctr(a_ctr[g]), .num_blocks(a_nb[g]),
      .ks_valid(a_kv[g]), .ks_ready(a_kr[g]), .ks_block(a_blk[g]),
      .ks_ctr(a_ko[g]), .ks_last(a_last[g]), .ctr_wrap(a_wrap[g]), .busy(a_busy[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  // Reference ChaCha block, written straight from the algorithm definition.
  function automatic logic [127:0] qr(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    a += b; d ^= a; d = {d[15:0], d[31:16]};
    c += d; b ^= c; b = {b[19:0], b[31:20]};
    a += b; d ^= a; d = {d[23:0], d[31:24]};
    c += d; b ^= c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_ref(logic [255:0] k, logic [95:0] n, logic [63:0] c,
                                              int rounds, bit c64);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c[31:0];
    s[13] = c64 ? c[63:32] : n[31:0];
    s[14] = n[63:32];
    s[15] = n[95:64];
    x = s;
    for (int r = 0; r < rounds / 2; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  typedef struct {
    logic [511:0] blk;
    logic [31:0]  ctr;
    bit           last;
  } exp_t;

  exp_t         q[$];
  logic [511:0] last_blk = '0;

  // Scoreboard: every presented block must match the queue head until accepted.
  always @(negedge clk) begin
    if (!rst && ks_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        chk("blk", ks_block, q[0].blk);
        chk("ctr", ks_ctr, q[0].ctr);
        chk("last", ks_last, q[0].last);
        if (ks_ready) begin
          last_blk = q[0].blk;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic wait_main(output int cnt);
    cnt = 0;
    while (!ks_valid && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!ks_valid) chk("timeout_ks_valid", 0, 1);
  endtask

  task automatic send_main(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           input int nb);
    int          eff, cnt;
    logic [31:0] cc;
    exp_t        e;
    eff = (nb == 0) ? 1 : nb;
    cc  = c;
    for (int b = 0; b < eff; b++) begin
      e.blk  = chacha_ref(k, n, {32'h0, cc}, 20, 1'b0);
      e.ctr  = cc;
      e.last = (b == eff - 1) || (cc == 32'hFFFFFFFF);
      q.push_back(e);
      if (e.last) break;
      cc++;
    end
    chk("job_ready_idle", job_ready, 1);
    key = k; nonce = n; init_ctr = c; num_blocks = 16'(nb);
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    wait_main(cnt);
    chk("latency", cnt, 22);
  endtask

  task automatic consume(input int stall);
    int cnt;
    wait_main(cnt);
    repeat (stall) begin @(posedge clk); #1; end
    ks_ready = 1'b1;
    @(posedge clk); #1;
    ks_ready = 1'b0;
  endtask

  task automatic run_aux(input int g, input int rounds, input logic [63:0] c, input int nb);
    logic [255:0] k;
    logic [95:0]  n;
    logic [63:0]  cc;
    int           cnt;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) n[32*i +: 32] = $urandom;
    a_key[g] = k; a_non[g] = n; a_ctr[g] = c; a_nb[g] = 16'(nb);
    a_jv[g] = 1'b1;
    @(posedge clk); #1;
    a_jv[g] = 1'b0;
    cc = c;
    for (int b = 0; b < nb; b++) begin
      cnt = 0;
      while (!a_kv[g] && cnt < 400) begin @(posedge clk); #1; cnt++; end
      if (!a_kv[g]) begin chk("aux_timeout", 0, 1); return; end
      if (b == 0) chk("aux_latency", cnt, rounds + 2);
      chk("aux_blk", a_blk[g], chacha_ref(k, n, cc, rounds, 1'b1));
      chk("aux_ctr", a_ko[g], cc);
      chk("aux_last", a_last[g], (b == nb - 1));
      a_kr[g] = 1'b1;
      @(posedge clk); #1;
      a_kr[g] = 1'b0;
      cc++;
    end
    chk("aux_idle", a_busy[g], 0);
  endtask

  logic [255:0] rfc_key, rk;
  logic [95:0]  rfc_non, rn;
  logic [511:0] rv;

  initial begin
    for (int g = 0; g < 2; g++) begin
      a_jv[g] = 0; a_kr[g] = 0; a_key[g] = '0; a_non[g] = '0; a_ctr[g] = '0; a_nb[g] = '0;
    end
    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    rfc_non = 96'h00000000_4a000000_09000000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_ks_valid", ks_valid, 0);
    chk("rst_ks_block", ks_block, 0);
    chk("rst_ks_ctr", ks_ctr, 0);
    chk("rst_ks_last", ks_last, 0);
    chk("rst_ctr_wrap", ctr_wrap, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    rv = chacha_ref(rfc_key, rfc_non, 64'd1, 20, 1'b0);
    chk("model_w0", rv[31:0], 32'he4e7f110);
    chk("model_w1", rv[63:32], 32'h15593bd1);
    chk("model_w15", rv[511:480], 32'h4e3c50a2);

    // RFC 8439 single block
    send_main(rfc_key, rfc_non, 32'd1, 1);
    chk("rfc_w0", ks_block[31:0], 32'he4e7f110);
    chk("rfc_w15", ks_block[511:480], 32'h4e3c50a2);
    chk("rfc_ctr", ks_ctr, 1);
    chk("rfc_last", ks_last, 1);
    consume(0);
    chk("idle_after_last", job_ready, 1);
`ifdef CHACHA_ZEROIZE_EN
    chk("zeroized_block", ks_block, 0);
`else
    chk("retained_block", ks_block, last_blk);
`endif
    chk("queue_empty_1", q.size(), 0);

    // three blocks, stall on the second
    send_main(rfc_key, rfc_non, 32'd1, 3);
    consume(0);
    consume(10);
    consume(0);
    chk("queue_empty_3", q.size(), 0);
    chk("idle_after_3", busy, 0);

    // counter wrap truncates the job
    send_main(rfc_key, rfc_non, 32'hFFFFFFFE, 4);
    consume(0);
    consume(0);
    chk("wrap_set", ctr_wrap, 1);
    chk("wrap_idle", busy, 0);
    chk("queue_empty_wrap", q.size(), 0);
    ks_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    ks_ready = 1'b0;
    chk("wrap_sticky", ctr_wrap, 1);
    chk("ready_no_valid", ks_valid, 0);

    // num_blocks=0 behaves as one block; accept clears ctr_wrap
    for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) rn[32*i +: 32] = $urandom;
    send_main(rk, rn, 32'd5, 0);
    chk("wrap_cleared", ctr_wrap, 0);
    consume(0);
    chk("queue_empty_nb0", q.size(), 0);
    chk("idle_nb0", busy, 0);

    // async reset during the rounds of block 2
    send_main(rk, rn, 32'd7, 3);
    consume(0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_valid", ks_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", job_ready, 1);
    chk("midrst_block", ks_block, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
    send_main(rk, rn, 32'h1234, 1);
    consume(0);
    chk("queue_empty_post_rst", q.size(), 0);

    // reduced rounds, 64-bit counter layout
    run_aux(0, 8,  {$urandom, 32'h0000_1000}, 1);
    run_aux(1, 12, {$urandom, 32'h0000_2000}, 1);
    run_aux(0, 8,  64'h00000000_FFFFFFFF, 2);
    run_aux(1, 12, 64'h00000001_00000000, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
